// File: rtl/uart_msg_tx.sv
// Streams a parameter string (optionally CR/LF terminated) into a byte UART over a start/busy handshake.
// First tx_start one cycle after the trigger edge; each byte waits for the UART busy pulse (or ACK timeout) before the next.
module uart_msg_tx #(
    parameter int                   MSG_LEN     = 12,
    parameter logic [8*MSG_LEN-1:0] MSG         = "Hello World!",
    parameter bit                   APPEND_CRLF = 1'b0,
    parameter bit                   MODE        = 1'b0,
    parameter int                   GAP_CYCLES  = 0,
    parameter int                   ACK_TIMEOUT = 15,
    localparam int                  N_BYTES     = MSG_LEN + 2 * int'(APPEND_CRLF),
    localparam int                  IDX_W       = (N_BYTES > 1) ? $clog2(N_BYTES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             enable,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             busy,
    output logic             done,
    output logic             ack_err,
    output logic [IDX_W-1:0] byte_idx
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND      = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic [7:0]       ACK_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);

    // Byte 0 is the leftmost character of MSG; CR then LF follow when enabled.
    function automatic logic [7:0] byte_at(input logic [IDX_W-1:0] idx);
        int i;
        i = int'(idx);
        if (i < MSG_LEN) begin
            return MSG[8*(MSG_LEN-1-i) +: 8];
        end else if (i == MSG_LEN) begin
            return 8'h0D;
        end else begin
            return 8'h0A;
        end
    endfunction

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       ack_cnt_q, ack_cnt_d;
    logic [15:0]      gap_cnt_q, gap_cnt_d;

    logic byte_cplt;
    logic ack_to;
    logic restart;
    logic last_byte;
    logic trigger;
    logic run_on;

    assign last_byte = (byte_idx_q == LAST_IDX);
    assign trigger   = MODE ? enable : start;
    assign run_on    = MODE && enable;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        tx_data_d  = tx_data_q;
        ack_cnt_d  = ack_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        byte_cplt  = 1'b0;
        ack_to     = 1'b0;
        restart    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trigger && !tx_busy) begin
                    restart = 1'b1;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    ack_to    = 1'b1;
                    byte_cplt = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_cplt = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (run_on) begin
                        restart = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A timed-out byte leaves through the same path as a normally completed one.
        if (byte_cplt) begin
            if (!last_byte) begin
                byte_idx_d = byte_idx_q + IDX_W'(1);
                tx_data_d  = byte_at(byte_idx_q + IDX_W'(1));
                state_d    = S_SEND;
            end else if (GAP_CYCLES > 0) begin
                gap_cnt_d = '0;
                state_d   = S_GAP;
            end else if (run_on) begin
                restart = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (restart) begin
            byte_idx_d = '0;
            tx_data_d  = byte_at('0);
            state_d    = S_SEND;
        end

        if (state_d == S_SEND) begin
            ack_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            tx_data_q  <= 8'h00;
            ack_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            tx_data_q  <= tx_data_d;
            ack_cnt_q  <= ack_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign tx_start = (state_q == S_SEND);
    assign busy     = (state_q != S_IDLE);
    assign done     = byte_cplt && last_byte;
    assign ack_err  = ack_to;
    assign tx_data  = tx_data_q;
    assign byte_idx = byte_idx_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: three configurations driven by randomized UART busy lengths,
// compared against byte lists and handshake timing derived from the message strings.
module tb_uart_msg_tx;

    typedef logic [7:0] bq_t[$];
    typedef int         iq_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // "Hello World!", one-shot
    logic       a_start = 1'b0, a_enable = 1'b0, a_tx_busy = 1'b0;
    logic       a_tx_start, a_busy, a_done, a_ack_err;
    logic [7:0] a_tx_data;
    logic [3:0] a_byte_idx;
    // "A" + CR/LF, one-shot, short ACK timeout
    logic       b_start = 1'b0, b_enable = 1'b0, b_tx_busy = 1'b0;
    logic       b_tx_start, b_busy, b_done, b_ack_err;
    logic [7:0] b_tx_data;
    logic [1:0] b_byte_idx;
    // "Hi", continuous with a 5-cycle gap
    logic       c_start = 1'b0, c_enable = 1'b0, c_tx_busy = 1'b0;
    logic       c_tx_start, c_busy, c_done, c_ack_err;
    logic [7:0] c_tx_data;
    logic [0:0] c_byte_idx;

    uart_msg_tx #(.MSG_LEN(12), .MSG("Hello World!")) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .enable(a_enable), .tx_busy(a_tx_busy),
        .tx_start(a_tx_start), .tx_data(a_tx_data), .busy(a_busy), .done(a_done),
        .ack_err(a_ack_err), .byte_idx(a_byte_idx));

    uart_msg_tx #(.MSG_LEN(1), .MSG("A"), .APPEND_CRLF(1'b1), .ACK_TIMEOUT(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .enable(b_enable), .tx_busy(b_tx_busy),
        .tx_start(b_tx_start), .tx_data(b_tx_data), .busy(b_busy), .done(b_done),
        .ack_err(b_ack_err), .byte_idx(b_byte_idx));

    uart_msg_tx #(.MSG_LEN(2), .MSG("Hi"), .MODE(1'b1), .GAP_CYCLES(5)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .enable(c_enable), .tx_busy(c_tx_busy),
        .tx_start(c_tx_start), .tx_data(c_tx_data), .busy(c_busy), .done(c_done),
        .ack_err(c_ack_err), .byte_idx(c_byte_idx));

    bq_t a_data_q, b_data_q, c_data_q;
    iq_t a_idx_q, a_ts_q, a_dn_q, a_ack_q, a_len_q;
    iq_t b_idx_q, b_ts_q, b_dn_q, b_ack_q, b_len_q;
    iq_t c_idx_q, c_ts_q, c_dn_q, c_ack_q, c_len_q;

    // Observed events, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (a_tx_start) begin
            a_data_q.push_back(a_tx_data); a_idx_q.push_back(int'(a_byte_idx)); a_ts_q.push_back(cyc);
        end
        if (a_done)    a_dn_q.push_back(cyc);
        if (a_ack_err) a_ack_q.push_back(cyc);
        if (b_tx_start) begin
            b_data_q.push_back(b_tx_data); b_idx_q.push_back(int'(b_byte_idx)); b_ts_q.push_back(cyc);
        end
        if (b_done)    b_dn_q.push_back(cyc);
        if (b_ack_err) b_ack_q.push_back(cyc);
        if (c_tx_start) begin
            c_data_q.push_back(c_tx_data); c_idx_q.push_back(int'(c_byte_idx)); c_ts_q.push_back(cyc);
        end
        if (c_done)    c_dn_q.push_back(cyc);
        if (c_ack_err) c_ack_q.push_back(cyc);
    end

    // UART models: busy for a random 1..8 cycles starting the cycle after tx_start (or never, b_dead).
    int a_rem = 0, b_rem = 0, c_rem = 0;
    bit b_dead = 1'b0;
    initial forever begin
        int l;
        @(posedge clk);
        #1;
        a_tx_busy = (a_rem > 0); if (a_rem > 0) a_rem--;
        b_tx_busy = (b_rem > 0); if (b_rem > 0) b_rem--;
        c_tx_busy = (c_rem > 0); if (c_rem > 0) c_rem--;
        if (a_tx_start) begin l = int'($urandom_range(8, 1)); a_rem = l; a_len_q.push_back(l); end
        if (b_tx_start) begin l = b_dead ? 0 : int'($urandom_range(8, 1)); b_rem = l; b_len_q.push_back(l); end
        if (c_tx_start) begin l = int'($urandom_range(8, 1)); c_rem = l; c_len_q.push_back(l); end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t msg_bytes(input string s, input bit crlf);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        if (crlf) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        return q;
    endfunction

    // A byte completes the cycle its busy pulse has ended, or ack_to cycles after tx_start
    // when the UART never answers; the next tx_start follows one cycle (plus the gap at message ends).
    task automatic check_stream(input string tag, input bq_t exp, input int reps, input int ack_to,
                                input int gap, input bq_t data, input iq_t idx, input iq_t ts,
                                input iq_t len, input iq_t dn);
        int n;
        int cplt;
        n = exp.size();
        check({tag, "_starts"}, 32'(ts.size()), 32'(n * reps));
        check({tag, "_dones"}, 32'(dn.size()), 32'(reps));
        for (int i = 0; i < ts.size() && i < data.size() && i < n * reps; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(data[i]), 32'(exp[i % n]));
            check($sformatf("%s_idx%0d", tag, i), idx[i], 32'(i % n));
            cplt = (len[i] > 0) ? ts[i] + len[i] + 1 : ts[i] + ack_to;
            if (i % n == n - 1) begin
                if (i / n < dn.size()) check($sformatf("%s_done%0d", tag, i / n), dn[i / n], cplt);
                if (i + 1 < ts.size()) check($sformatf("%s_gap%0d", tag, i), ts[i + 1], cplt + 1 + gap);
            end else if (i + 1 < ts.size()) begin
                check($sformatf("%s_next%0d", tag, i), ts[i + 1], cplt + 1);
            end
        end
    endtask

    task automatic clear_all();
        a_data_q.delete(); a_idx_q.delete(); a_ts_q.delete(); a_dn_q.delete(); a_ack_q.delete(); a_len_q.delete();
        b_data_q.delete(); b_idx_q.delete(); b_ts_q.delete(); b_dn_q.delete(); b_ack_q.delete(); b_len_q.delete();
        c_data_q.delete(); c_idx_q.delete(); c_ts_q.delete(); c_dn_q.delete(); c_ack_q.delete(); c_len_q.delete();
    endtask

    task automatic nwait();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int which, output int t_set);
        @(posedge clk);
        #2;
        if (which == 0) a_start = 1'b1; else b_start = 1'b1;
        t_set = cyc;
        @(posedge clk);
        #2;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    initial begin
        bq_t exp_a, exp_b, exp_c;
        int  t0;
        exp_a = msg_bytes("Hello World!", 1'b0);
        exp_b = msg_bytes("A", 1'b1);
        exp_c = msg_bytes("Hi", 1'b0);

        // Reset values, during and after reset.
        repeat (3) @(posedge clk);
        #2;
        check("rst_a_tx_start", 32'(a_tx_start), 32'(0));
        check("rst_a_busy", 32'(a_busy), 32'(0));
        check("rst_a_tx_data", 32'(a_tx_data), 32'(0));
        check("rst_a_byte_idx", 32'(a_byte_idx), 32'(0));
        check("rst_b_done", 32'(b_done), 32'(0));
        check("rst_b_ack_err", 32'(b_ack_err), 32'(0));
        rst_n = 1'b1;
        repeat (3) nwait();
        check("idle_a_busy", 32'(a_busy), 32'(0));
        check("idle_c_busy", 32'(c_busy), 32'(0));
        check("idle_b_tx_start", 32'(b_tx_start), 32'(0));

        // One-shot message with random UART busy lengths.
        clear_all();
        pulse_start(0, t0);
        check("a_lat_tx_start", 32'(a_tx_start), 32'(1));
        check("a_lat_busy", 32'(a_busy), 32'(1));
        for (int k = 0; k < 3000 && a_dn_q.size() < 1; k++) nwait();
        nwait();
        check("a_busy_after_done", 32'(a_busy), 32'(0));
        check("a_first_ts", a_ts_q.size() > 0 ? a_ts_q[0] : -1, t0 + 1);
        check_stream("msg_a", exp_a, 1, 15, 0, a_data_q, a_idx_q, a_ts_q, a_len_q, a_dn_q);

        // start re-pulsed while busy is neither honoured nor queued.
        clear_all();
        pulse_start(0, t0);
        for (int k = 0; k < 3000 && a_ts_q.size() < 3; k++) nwait();
        pulse_start(0, t0);
        for (int k = 0; k < 3000 && a_ts_q.size() < 7; k++) nwait();
        pulse_start(0, t0);
        for (int k = 0; k < 3000 && a_dn_q.size() < 1; k++) nwait();
        repeat (30) nwait();
        check_stream("repulse_a", exp_a, 1, 15, 0, a_data_q, a_idx_q, a_ts_q, a_len_q, a_dn_q);

        // Asynchronous reset in the middle of byte 3.
        clear_all();
        pulse_start(0, t0);
        for (int k = 0; k < 3000 && a_ts_q.size() < 4; k++) nwait();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx_start", 32'(a_tx_start), 32'(0));
        check("midrst_busy", 32'(a_busy), 32'(0));
        check("midrst_tx_data", 32'(a_tx_data), 32'(0));
        check("midrst_byte_idx", 32'(a_byte_idx), 32'(0));
        check("midrst_done", 32'(a_done), 32'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_all();
        repeat (20) nwait();
        check("midrst_no_rerequest", 32'(a_ts_q.size()), 32'(0));
        check("midrst_idle", 32'(a_busy), 32'(0));
        pulse_start(0, t0);
        for (int k = 0; k < 3000 && a_dn_q.size() < 1; k++) nwait();
        nwait();
        check_stream("after_rst_a", exp_a, 1, 15, 0, a_data_q, a_idx_q, a_ts_q, a_len_q, a_dn_q);

        // CR/LF appended.
        clear_all();
        pulse_start(1, t0);
        for (int k = 0; k < 3000 && b_dn_q.size() < 1; k++) nwait();
        nwait();
        check_stream("crlf_b", exp_b, 1, 4, 0, b_data_q, b_idx_q, b_ts_q, b_len_q, b_dn_q);
        check("crlf_b_no_ack_err", 32'(b_ack_q.size()), 32'(0));

        // UART never answers: each byte times out and the message still finishes.
        clear_all();
        b_dead = 1'b1;
        pulse_start(1, t0);
        for (int k = 0; k < 3000 && b_dn_q.size() < 1; k++) nwait();
        nwait();
        check_stream("ackto_b", exp_b, 1, 4, 0, b_data_q, b_idx_q, b_ts_q, b_len_q, b_dn_q);
        check("ackto_count", 32'(b_ack_q.size()), 32'(3));
        for (int i = 0; i < b_ack_q.size() && i < b_ts_q.size(); i++)
            check($sformatf("ackto_cycle%0d", i), b_ack_q[i], b_ts_q[i] + 4);
        check("ackto_with_done", b_ack_q.size() > 2 ? b_ack_q[2] : -1, b_dn_q.size() > 0 ? b_dn_q[0] : -2);
        b_dead = 1'b0;

        // Continuous mode: enable dropped part-way through the third message.
        clear_all();
        @(posedge clk);
        #2;
        c_enable = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 3000 && c_ts_q.size() < 5; k++) nwait();
        @(posedge clk);
        #2;
        c_enable = 1'b0;
        for (int k = 0; k < 3000 && c_dn_q.size() < 3; k++) nwait();
        repeat (5) nwait();
        check("c_busy_in_gap", 32'(c_busy), 32'(1));
        nwait();
        check("c_idle_after_gap", 32'(c_busy), 32'(0));
        repeat (30) nwait();
        check("c_first_ts", c_ts_q.size() > 0 ? c_ts_q[0] : -1, t0 + 1);
        check_stream("cont_c", exp_c, 3, 15, 5, c_data_q, c_idx_q, c_ts_q, c_len_q, c_dn_q);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_msg_tx.md
# uart_msg_tx

Parametrised message sequencer that streams a fixed ASCII string into a byte-wide UART transmitter over a start/busy handshake. The string is given as a parameter, and CR/LF can optionally be appended. It runs in one-shot mode (one message per `start`) or continuous mode (repeats while `enable` is high, with a programmable inter-message gap). It sits between board-level control logic and the UART core, driving the core's `transmit`/`tx_byte` inputs and watching its `is_transmitting` output.

## Interface
- `MSG`, default "Hello World!": message string; byte 0 is the leftmost character, i.e. `MSG[8*(MSG_LEN-1-i) +: 8]`.
- `MSG_LEN`, default 12: characters in `MSG`, 1..256.
- `APPEND_CRLF`, default 0: when 1, send 0x0D then 0x0A after the last `MSG` byte.
- `MODE`, default 0: 0 = one-shot on `start`; 1 = continuous while `enable`.
- `GAP_CYCLES`, default 0: idle clocks after each message, 0..2^16-1.
- `ACK_TIMEOUT`, default 15: clocks to wait for `tx_busy` to rise after `tx_start`, 1..255.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-shot trigger (MODE 0); sampled only in IDLE.
- `enable`  in  1  continuous-run gate (MODE 1); ignored in MODE 0.
- `tx_busy`  in  1  UART `is_transmitting`.
- `tx_start`  out  1  one-cycle transmit request to the UART.
- `tx_data`  out  8  byte to transmit; valid from `tx_start` until the next `tx_start`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the last byte of a message completes.
- `ack_err`  out  1  one-cycle pulse when an ACK timeout occurs.
- `byte_idx`  out  IDX_W  index of the byte in flight; IDX_W = max(1, clog2(MSG_LEN+2*APPEND_CRLF)).

## Operation
- Total length is N = MSG_LEN + 2*APPEND_CRLF. Byte i < MSG_LEN comes from `MSG`; byte MSG_LEN is 0x0D and byte MSG_LEN+1 is 0x0A.
- FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE, GAP.
- IDLE: leave when (MODE 0 and `start`) or (MODE 1 and `enable`) and `tx_busy` = 0. On leaving, load `byte_idx` = 0 and `tx_data` = byte 0, then go to SEND.
- SEND: lasts exactly one cycle with `tx_start` = 1, then goes to WAIT_ACK. The ACK counter clears on entry.
- WAIT_ACK:
  - `tx_busy` = 1 -> WAIT_DONE.
  - Counter reaching ACK_TIMEOUT -> pulse `ack_err` and treat the byte as complete (same exit as WAIT_DONE completion).
- WAIT_DONE: on `tx_busy` = 0, the byte is complete.
  - If `byte_idx` < N-1: increment `byte_idx`, load the next `tx_data`, go to SEND.
  - If `byte_idx` = N-1: pulse `done`, then go to GAP if GAP_CYCLES > 0.
  - Otherwise (GAP_CYCLES = 0), apply the GAP exit rule directly.
- GAP: the counter runs GAP_CYCLES clocks, then applies the exit rule.
  - MODE 1 with `enable` = 1 -> restart at byte 0 (SEND).
  - Otherwise -> IDLE.
- Messages are never truncated:
  - `enable` falling mid-message only stops the next repeat.
  - `start` while `busy` = 1 is ignored and not queued.
- Byte selection is combinational from the `MSG` parameter. `tx_data` is a register updated only on a SEND entry.

## Timing
- Reset (async assert, sync release): state IDLE; `tx_start`, `busy`, `done`, `ack_err` = 0; `tx_data` = 0x00; `byte_idx` = 0; all counters 0.
- Trigger latency: `start` sampled high at edge k gives `tx_start` = 1 and `busy` = 1 in cycle k+1.
- Byte-to-byte: `tx_start` for byte i+1 is asserted the cycle after `tx_busy` is sampled low in WAIT_DONE.
- `done` is asserted in the same cycle the FSM leaves WAIT_DONE for the last byte. `busy` stays 1 through GAP.
- MODE 1 repeat: the first `tx_start` of the next message comes GAP_CYCLES+1 cycles after `done`, or 1 cycle after when GAP_CYCLES = 0.
- `ack_err` on the last byte pulses in the same cycle as `done`.
- Reset asserted mid-message: outputs go to reset values immediately. No partial byte is re-requested after release.
- N = 1: SEND -> WAIT_ACK -> WAIT_DONE -> done. `byte_idx` stays 0.

## Test plan
- MODE 0, MSG="Hi", MSG_LEN=2, UART model busy 10 cycles starting 1 cycle after `tx_start`; pulse `start` -> `tx_data` 0x48 then 0x69, exactly two `tx_start` pulses, one `done`, `busy` low the cycle after `done`.
- MODE 0, APPEND_CRLF=1, MSG="A" -> bytes 0x41, 0x0D, 0x0A; `byte_idx` 0, 1, 2; single `done` on the 0x0A completion.
- MODE 1, GAP_CYCLES=5, `enable` held high for 2.5 messages then dropped -> 3 complete messages, exactly 5 idle cycles between `done` and the next `tx_start`, no truncation, IDLE after the third `done`.
- ACK timeout: UART model never raises `tx_busy`, ACK_TIMEOUT=4 -> `ack_err` pulses 4 cycles after each `tx_start`; the sequencer advances through all bytes and pulses `done`.
- `start` re-pulsed mid-message -> ignored; exactly MSG_LEN `tx_start` pulses total.
- `rst_n` asserted during byte 3 of "Hello World!" -> outputs reset immediately, IDLE after release; next `start` begins at 0x48.
